// File: rtl/llb_proto_pkg.sv
// Shared protocol definitions for the LLB link: ASCII framing constants and
// the frame-sequencer state encoding used by both output and input handlers.
package llb_proto_pkg;

  localparam logic [7:0] ASCII_ID = 8'h4C;  // 'L'
  localparam logic [7:0] ASCII_LF = 8'h0A;  // frame terminator

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID,
    ST_CMD,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_TERM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex character converter.
module hex_to_ascii (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  // Map 0-9 to '0'-'9' and 10-15 to 'A'-'F'.
  always_comb begin
    // NOTE: every path assigns ascii_o, so no latch is inferred.
    if (nibble_i < 4'd10) begin
      ascii_o = 8'h30 + {4'h0, nibble_i};
    end else begin
      ascii_o = 8'h41 + ({4'h0, nibble_i} - 8'd10);
    end
  end

endmodule

// File: rtl/output_handler.sv
// Frame serializer: emits ID, command, two length chars, payload hex chars
// and LF as a valid/ready ASCII byte stream. The byte output is named byte_o
// because "byte" is a reserved word in SystemVerilog.
module output_handler
  import llb_proto_pkg::*;
#(
  parameter logic [7:0] ID_CHAR = ASCII_ID,
  parameter int         BUF_W   = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       command,
  input  logic [7:0]       data_count,
  input  logic [BUF_W-1:0] buffer,
  output logic [7:0]       byte_o,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             busy,
  output logic             done
);

  localparam int MAX_LEN = BUF_W / 4;

  state_t           state_q;
  logic [3:0]       cmd_q;
  logic [7:0]       len_q;
  logic [BUF_W-1:0] buf_q;
  logic [6:0]       cnt_q;
  logic [7:0]       byte_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [7:0] len_d;
  logic [3:0] nib_d;
  logic [7:0] hex_char;
  logic       xfer;
  logic       last_nib;

  assign xfer     = valid_q && byte_ready;
  assign last_nib = ({1'b0, cnt_q} == (len_q - 8'd1));

  // Clamp the requested nibble count to what the buffer can hold.
  always_comb begin
    len_d = data_count;
    if (int'(data_count) > MAX_LEN) begin
      len_d = 8'(MAX_LEN);
    end
  end

  // Select the nibble whose character is presented after the current byte
  // transfers; the payload buffer shifts left so its top nibble is always next.
  always_comb begin
    nib_d = 4'h0;
    case (state_q)
      ST_ID:     nib_d = cmd_q;
      ST_CMD:    nib_d = len_q[7:4];
      ST_LEN_HI: nib_d = len_q[3:0];
      ST_LEN_LO: nib_d = buf_q[BUF_W-1 -: 4];
      ST_DATA:   nib_d = buf_q[BUF_W-5 -: 4];
      default:   nib_d = 4'h0;
    endcase
  end

  hex_to_ascii u_hex (
    .nibble_i (nib_d),
    .ascii_o  (hex_char)
  );

  // Frame sequencer with registered byte/valid/busy/done outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= 4'h0;
      len_q   <= 8'h00;
      // NOTE: the payload latch is a plain register (not a memory), so it is
      // cleared on reset like the rest of the frame context.
      buf_q   <= '0;
      cnt_q   <= 7'd0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cmd_q   <= command;
            len_q   <= len_d;
            buf_q   <= buffer;
            cnt_q   <= 7'd0;
            byte_q  <= ID_CHAR;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_ID;
          end
        end
        ST_ID: begin
          if (xfer) begin
            byte_q  <= hex_char;
            state_q <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (xfer) begin
            byte_q  <= hex_char;
            state_q <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            byte_q  <= hex_char;
            state_q <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            if (len_q == 8'd0) begin
              byte_q  <= ASCII_LF;
              state_q <= ST_TERM;
            end else begin
              byte_q  <= hex_char;
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            cnt_q <= cnt_q + 7'd1;
            buf_q <= buf_q << 4;
            if (last_nib) begin
              byte_q  <= ASCII_LF;
              state_q <= ST_TERM;
            end else begin
              byte_q  <= hex_char;
            end
          end
        end
        ST_TERM: begin
          if (xfer) begin
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign byte_o     = byte_q;
  assign byte_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_output_handler.sv
// Directed self-checking bench for output_handler.
module tb_output_handler;

  localparam int BUF_W = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       command;
  logic [7:0]       data_count;
  logic [BUF_W-1:0] buffer;
  logic [7:0]       byte_o;
  logic             byte_valid;
  logic             byte_ready;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got[$];
  int         got_cyc[$];
  logic [7:0] stall_seen[$];
  int         done_cyc;
  bit         timed_out;
  int         done_bad;
  int         busy_bad;

  logic [7:0] exp_basic [21] = '{8'h4C, 8'h31, 8'h31, 8'h30, 8'h30, 8'h31, 8'h32,
                                 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0A};
  logic [7:0] exp_zero [5] = '{8'h4C, 8'h41, 8'h30, 8'h30, 8'h0A};

  always #5 clk = ~clk;

  output_handler #(.ID_CHAR(8'h4C), .BUF_W(BUF_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .command    (command),
    .data_count (data_count),
    .buffer     (buffer),
    .byte_o     (byte_o),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [7:0] hex_exp(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] got_at(input int k);
    if (k < got.size()) return got[k];
    return 8'hxx;
  endfunction

  // Pulse start for one cycle; returns at the negedge where ID should show.
  task automatic begin_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Collect transferred bytes until done (bounded). Optionally stall ready
  // for stall_cnt cycles while byte index stall_idx is presented, and pulse
  // start with a changed command while byte index poke_idx is presented.
  task automatic capture(input int stall_idx, input int stall_cnt, input int poke_idx);
    int  stall_left;
    bit  poked;
    stall_left = stall_cnt;
    poked      = 1'b0;
    got.delete();
    got_cyc.delete();
    stall_seen.delete();
    timed_out = 1'b1;
    done_cyc  = -1;
    done_bad  = 0;
    busy_bad  = 0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        done_cyc  = i;
        timed_out = 1'b0;
        if (byte_valid || busy) done_bad = 1;
        break;
      end
      if (int'(got.size()) == stall_idx && stall_left > 0) begin
        byte_ready = 1'b0;
        stall_left--;
        if (byte_valid) stall_seen.push_back(byte_o);
      end else begin
        byte_ready = 1'b1;
      end
      if (int'(got.size()) == poke_idx && !poked) begin
        start   = 1'b1;
        command = 4'hF;
        poked   = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (byte_valid && !busy) busy_bad++;
      if (byte_valid && byte_ready) begin
        got.push_back(byte_o);
        got_cyc.push_back(i);
      end
      @(negedge clk);
    end
    start      = 1'b0;
    byte_ready = 1'b1;
  endtask

  task automatic setup_basic();
    command    = 4'h1;
    data_count = 8'h10;
    buffer     = {64'h0123456789ABCDEF, 192'h0};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; command = 4'h3; data_count = 8'h04;
    buffer = '1; byte_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (byte_o !== 8'h00 || byte_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: byte=%h valid=%b busy=%b done=%b, want 00 0 0 0",
               byte_o, byte_valid, busy, done);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (byte_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: valid=%b busy=%b, want 0 0", byte_valid, busy);
    end
  endtask

  task automatic test_basic();
    setup_basic();
    begin_frame();
    capture(-1, 0, -1);
    checks++;
    if (timed_out || got.size() != 21) begin
      failures++;
      $display("FAIL basic_len: got %0d bytes timeout=%b, want 21", got.size(), timed_out);
    end
    for (int k = 0; k < 21; k++) begin
      checks++;
      if (got_at(k) !== exp_basic[k]) begin
        failures++;
        $display("FAIL basic_byte[%0d]: got %h, want %h", k, got_at(k), exp_basic[k]);
      end
    end
    for (int k = 0; k < int'(got_cyc.size()); k++) begin
      checks++;
      if (got_cyc[k] != k) begin
        failures++;
        $display("FAIL basic_cycle[%0d]: got %0d, want %0d", k, got_cyc[k], k);
      end
    end
    checks++;
    if (done_cyc != 21 || done_bad != 0 || busy_bad != 0) begin
      failures++;
      $display("FAIL basic_done: cyc=%0d bad=%0d busy_bad=%0d, want 21 0 0",
               done_cyc, done_bad, busy_bad);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || byte_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: done=%b valid=%b busy=%b, want 0 0 0",
               done, byte_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    setup_basic();
    begin_frame();
    capture(3, 3, -1);
    checks++;
    if (timed_out || got.size() != 21) begin
      failures++;
      $display("FAIL bp_len: got %0d bytes timeout=%b, want 21", got.size(), timed_out);
    end
    for (int k = 0; k < 21; k++) begin
      checks++;
      if (got_at(k) !== exp_basic[k]) begin
        failures++;
        $display("FAIL bp_byte[%0d]: got %h, want %h", k, got_at(k), exp_basic[k]);
      end
    end
    checks++;
    if (stall_seen.size() != 3) begin
      failures++;
      $display("FAIL bp_hold_valid: held-valid cycles %0d, want 3", stall_seen.size());
    end
    foreach (stall_seen[k]) begin
      checks++;
      if (stall_seen[k] !== 8'h30) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got %h, want 30", k, stall_seen[k]);
      end
    end
    checks++;
    if (got_cyc.size() != 21 || got_cyc[3] != 6 || got_cyc[20] != 23 || done_cyc != 24) begin
      failures++;
      $display("FAIL bp_timing: lenlo_cyc=%0d term_cyc=%0d done_cyc=%0d, want 6 23 24",
               got_cyc.size() > 3 ? got_cyc[3] : -1,
               got_cyc.size() > 20 ? got_cyc[20] : -1, done_cyc);
    end
  endtask

  task automatic test_zero_len();
    command = 4'hA; data_count = 8'h00; buffer = '1;
    begin_frame();
    capture(-1, 0, -1);
    checks++;
    if (timed_out || got.size() != 5) begin
      failures++;
      $display("FAIL zero_len: got %0d bytes timeout=%b, want 5", got.size(), timed_out);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (got_at(k) !== exp_zero[k]) begin
        failures++;
        $display("FAIL zero_byte[%0d]: got %h, want %h", k, got_at(k), exp_zero[k]);
      end
    end
  endtask

  task automatic test_clamp();
    int bad;
    command = 4'h2; data_count = 8'h50; buffer = {4{64'h0123456789ABCDEF}};
    begin_frame();
    capture(-1, 0, -1);
    checks++;
    if (timed_out || got.size() != 69) begin
      failures++;
      $display("FAIL clamp_len: got %0d bytes timeout=%b, want 69", got.size(), timed_out);
    end
    checks++;
    if (got_at(2) !== 8'h34 || got_at(3) !== 8'h30) begin
      failures++;
      $display("FAIL clamp_field: got %h %h, want 34 30", got_at(2), got_at(3));
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      logic [3:0] n;
      n = 4'(i % 16);
      if (got_at(4 + i) !== hex_exp(n)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clamp_payload: %0d wrong chars, want 0", bad);
    end
    checks++;
    if (got_at(68) !== 8'h0A) begin
      failures++;
      $display("FAIL clamp_term: got %h, want 0a", got_at(68));
    end
  endtask

  task automatic test_start_ignored();
    int extra;
    setup_basic();
    begin_frame();
    capture(-1, 0, 10);
    checks++;
    if (timed_out || got.size() != 21) begin
      failures++;
      $display("FAIL ign_len: got %0d bytes timeout=%b, want 21", got.size(), timed_out);
    end
    for (int k = 0; k < 21; k++) begin
      checks++;
      if (got_at(k) !== exp_basic[k]) begin
        failures++;
        $display("FAIL ign_byte[%0d]: got %h, want %h", k, got_at(k), exp_basic[k]);
      end
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (byte_valid || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL ign_second_frame: active cycles %0d, want 0", extra);
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    setup_basic();
    byte_ready = 1'b1;
    begin_frame();
    repeat (5) @(negedge clk);
    checks++;
    if (byte_valid !== 1'b1 || byte_o !== 8'h31) begin
      failures++;
      $display("FAIL rst_pre: valid=%b byte=%h, want 1 31", byte_valid, byte_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (byte_valid !== 1'b0 || busy !== 1'b0 || byte_o !== 8'h00) begin
      failures++;
      $display("FAIL rst_abort: valid=%b busy=%b byte=%h, want 0 0 00",
               byte_valid, busy, byte_o);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || byte_valid) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_no_done: active cycles %0d, want 0", bad);
    end
    begin_frame();
    checks++;
    if (byte_valid !== 1'b1 || byte_o !== 8'h4C) begin
      failures++;
      $display("FAIL rst_restart: valid=%b byte=%h, want 1 4c", byte_valid, byte_o);
    end
    capture(-1, 0, -1);
    checks++;
    if (timed_out || got.size() != 21 || got_at(20) !== 8'h0A) begin
      failures++;
      $display("FAIL rst_refrm: got %0d bytes last=%h, want 21 0a", got.size(), got_at(20));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_clamp();
    test_start_ignored();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/output_handler.md
OUTPUT_HANDLER -- requirements
Module: output_handler

Interface
REQ-001 SHALL have parameter ID_CHAR, default 8'h4C ('L'), the frame ID byte sent first.
REQ-002 SHALL have parameter BUF_W, default 256, the payload buffer width in bits.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, which requests a frame and is sampled only in IDLE.
REQ-006 SHALL have port command, input, 4 bits, the response command code.
REQ-007 SHALL have port data_count, input, 8 bits, the number of payload hex characters (nibbles) to send.
REQ-008 SHALL have port buffer, input, BUF_W bits, the payload, most-significant nibble first.
REQ-009 SHALL have port byte, output, 8 bits, the current ASCII byte.
REQ-010 SHALL have port byte_valid, output, 1 bit, which marks byte as valid.
REQ-011 SHALL have port byte_ready, input, 1 bit, from the downstream transmitter; a byte transfers when byte_valid && byte_ready in the same cycle.
REQ-012 SHALL have port busy, output, 1 bit, high from frame acceptance until done.
REQ-013 SHALL have port done, output, 1 bit, a single-cycle pulse at frame completion.

Function
REQ-014 Frame order SHALL be: ID_CHAR; hex(command); hex(len[7:4]); hex(len[3:0]); len payload chars; 8'h0A terminator.
REQ-015 hex(n) SHALL map 0-9 to 8'h30+n and 10-15 to 8'h41+n-10 (uppercase).
REQ-016 len SHALL be min(data_count, BUF_W/4); the clamped value is also the value transmitted in the length field.
REQ-017 Payload char i (i = 0..len-1) SHALL be hex(buffer[BUF_W-1-4i -: 4]).
REQ-018 On start in IDLE, command, len and buffer SHALL be latched; later input changes SHALL not affect the frame.
REQ-019 byte_valid SHALL rise on the cycle after start is sampled, carrying ID_CHAR.
REQ-020 While byte_valid is high and byte_ready is low, byte SHALL hold stable and byte_valid SHALL stay high.
REQ-021 After each transfer, the next byte SHALL be presented on the following cycle with no bubble; sustained throughput SHALL be one byte per cycle.
REQ-022 States SHALL be IDLE, ID, CMD, LEN_HI, LEN_LO, DATA, TERM and DONE.
REQ-023 Transitions from ID through TERM SHALL occur on transfer; DATA SHALL be skipped when len == 0.
REQ-024 DONE SHALL last one cycle with done=1, byte_valid=0, busy=0, then return to IDLE.
REQ-025 The payload nibble counter SHALL be 7 bits, increment on each DATA transfer, and leave DATA when it reaches len-1 and that byte transfers.
REQ-026 start SHALL be ignored while busy or in DONE; start in IDLE SHALL be accepted even if it is held continuously.
REQ-027 busy SHALL equal state not in {IDLE, DONE}.

Reset
REQ-028 rst SHALL force IDLE with byte=8'h00, byte_valid=0, busy=0, done=0, counter=0, and latches cleared.
REQ-029 rst mid-frame SHALL abort the frame immediately, without sending a terminator or pulsing done.
REQ-030 rst SHALL take priority over start in the same cycle.

Structure
REQ-031 A shared package (llb_proto_pkg) SHALL hold the ASCII constants (ID 8'h4C, LF 8'h0A) and the state encoding, shared with input_handler.
REQ-032 A sub-module hex_to_ascii (4-bit in, 8-bit out, combinational) SHALL implement REQ-015.

Verification
REQ-033 Scenario: command=1, data_count=8'h10, buffer[255:192]=64'h0123456789ABCDEF, byte_ready=1 -> bytes 4C 31 31 30 30 31 32 33 34 35 36 37 38 39 41 42 43 44 45 46 0A on 21 consecutive cycles, then a done pulse.
REQ-034 Scenario: the same frame with byte_ready low for 3 cycles during LEN_LO -> byte is held at 8'h30 for those cycles and the stream is otherwise identical.
REQ-035 Scenario: data_count=0, command=4'hA -> bytes 4C 41 30 30 0A.
REQ-036 Scenario: data_count=8'h50 -> length chars 34 30 followed by exactly 64 payload chars.
REQ-037 Scenario: start pulsed during DATA, and command changed mid-frame -> no second frame and unchanged bytes.
REQ-038 Scenario: rst asserted after 5 bytes -> next cycle byte_valid=0, busy=0, done never pulses; a new start sends 4C first.
